apb_initiator: RTL

Single-outstanding APB initiator that turns a simple valid/ready command stream into APB3/APB4 read and write transfers and returns each result on a valid/ready response stream. It sits between a local controller (sequencer, debug bridge, analog-config engine) and any APB peripheral on the subsystem bus, e.g. the analog status/control register arrays. It also provides a watchdog so a hung peripheral cannot stall the controller.

---
 rtl/apb_pkg.sv | 33 +++
 rtl/apb_initiator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions for the APB initiator slice.
// Contents:
//   APB_ADDR_W / APB_DATA_W / APB_STRB_W - default bus widths
//   apb_state_e - transfer sequencer states
//   apb_cmd_t   - one queued command (addr, write, wdata, strb)
//   apb_rsp_t   - one returned response (rdata, err, timeout)
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 16;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_initiator.sv
// Single-outstanding APB3/APB4 initiator.
// Accepts one command on a valid/ready stream, runs one APB transfer and
// returns the result on a valid/ready response stream. A saturating wait
// counter aborts the transfer if the peripheral holds PREADY low for too
// long (TIMEOUT_CYCLES = 0 disables the abort).
// Ports:
//   clk_in, reset_n (async, active-low)
//   cmd_valid/cmd_ready, cmd_addr, cmd_write, cmd_wdata, cmd_strb - command in
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err, rsp_timeout           - response out
//   busy                                                           - not idle
//   PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB                    - APB request
//   PRDATA, PREADY, PSLVERR                                        - APB completion
module apb_initiator
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic                cmd_write,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                busy,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    apb_state_e       state;
    apb_state_e       next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             complete;
    logic             abort;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: next_state = ACCESS;
            ACCESS: begin
                // PREADY wins over an expiring counter in the same cycle.
                if (PREADY) begin
                    complete   = 1'b1;
                    next_state = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LIM)) begin
                    abort      = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PADDR       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= next_state;

            if (accept) begin
                PADDR    <= cmd_addr;
                PWRITE   <= cmd_write;
                PWDATA   <= cmd_wdata;
                PSTRB    <= cmd_write ? cmd_strb : '0;
                PSEL     <= 1'b1;
                wait_cnt <= '0;
            end

            if (state == SETUP) begin
                PENABLE <= 1'b1;
            end

            if (state == ACCESS) begin
                if (complete) begin
                    PSEL        <= 1'b0;
                    PENABLE     <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= PWRITE ? '0 : PRDATA;
                    rsp_err     <= PSLVERR;
                    rsp_timeout <= 1'b0;
                end else if (abort) begin
                    PSEL        <= 1'b0;
                    PENABLE     <= 1'b0;
                    rsp_valid   <= 1'b1;
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end else if (wait_cnt != CNT_MAX) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end

            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
